// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: mux-select enums, opcode map, ALU function codes
// and the decoded-instruction record with its decode function.
package decode_stage_pkg;

  typedef enum logic [1:0] {
    ARITH = 2'd0,
    LOGIC = 2'd1,
    SHIFT = 2'd2
  } alu_mux_sel_t;

  typedef enum logic [0:0] {
    REG1_DATA = 1'b0
  } x_op1_mux_sel_t;

  typedef enum logic [0:0] {
    REG2_DATA  = 1'b0,
    IMM_SIGNED = 1'b1
  } x_op2_mux_sel_t;

  typedef enum logic [0:0] {
    REG_WRITE = 1'b0
  } w_mux_sel_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADDI = 4'd8
  } opcode_t;

  localparam logic [1:0] ALU_FUNC_ADD = 2'd0;
  localparam logic [1:0] ALU_FUNC_SUB = 2'd1;
  localparam logic [1:0] ALU_FUNC_AND = 2'd0;
  localparam logic [1:0] ALU_FUNC_OR  = 2'd1;
  localparam logic [1:0] ALU_FUNC_XOR = 2'd2;
  localparam logic [1:0] ALU_FUNC_SHL = 2'd0;
  localparam logic [1:0] ALU_FUNC_SHR = 2'd1;

  // pc is parameter-width, so it travels beside this record rather than inside it
  typedef struct packed {
    logic [3:0]     rd;
    logic [15:0]    imm;
    alu_mux_sel_t   alu_sel;
    logic [1:0]     alu_func;
    x_op1_mux_sel_t op1_sel;
    x_op2_mux_sel_t op2_sel;
    w_mux_sel_t     w_sel;
    logic           reg_we;
    logic           illegal;
  } decoded_instr_t;

  localparam decoded_instr_t DECODED_NOP = '{
    rd:       4'd0,
    imm:      16'd0,
    alu_sel:  ARITH,
    alu_func: 2'd0,
    op1_sel:  REG1_DATA,
    op2_sel:  REG2_DATA,
    w_sel:    REG_WRITE,
    reg_we:   1'b0,
    illegal:  1'b0
  };

  function automatic decoded_instr_t decode_instr(input logic [15:0] instr);
    decoded_instr_t d;
    d          = DECODED_NOP;
    d.rd       = instr[11:8];
    d.imm      = {{12{instr[3]}}, instr[3:0]};
    case (instr[15:12])
      OP_NOP:  d.reg_we = 1'b0;
      OP_ADD:  begin d.alu_func = ALU_FUNC_ADD; d.reg_we = 1'b1; end
      OP_SUB:  begin d.alu_func = ALU_FUNC_SUB; d.reg_we = 1'b1; end
      OP_AND:  begin d.alu_sel = LOGIC; d.alu_func = ALU_FUNC_AND; d.reg_we = 1'b1; end
      OP_OR:   begin d.alu_sel = LOGIC; d.alu_func = ALU_FUNC_OR;  d.reg_we = 1'b1; end
      OP_XOR:  begin d.alu_sel = LOGIC; d.alu_func = ALU_FUNC_XOR; d.reg_we = 1'b1; end
      OP_SHL:  begin d.alu_sel = SHIFT; d.alu_func = ALU_FUNC_SHL; d.reg_we = 1'b1; end
      OP_SHR:  begin d.alu_sel = SHIFT; d.alu_func = ALU_FUNC_SHR; d.reg_we = 1'b1; end
      OP_ADDI: begin d.op2_sel = IMM_SIGNED; d.alu_func = ALU_FUNC_ADD; d.reg_we = 1'b1; end
      default: d.illegal = 1'b1;
    endcase
    // r0 is hardwired, so nothing ever writes it
    if (instr[11:8] == 4'd0) d.reg_we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Per-register busy bits with set-on-issue / clear-on-writeback and the RAW hazard query.
// Optional DECODE_WB_BYPASS_EN: a register retiring this cycle no longer counts as busy.
module decode_scoreboard
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       set_en,
  input  logic [3:0] set_addr,
  input  logic       wb_valid,
  input  logic [3:0] wb_addr,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  logic       use_rs2,
  output logic       hazard
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_eff;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    assign clr_vec[gi] = wb_valid && (wb_addr == 4'(gi));
    if (gi == 0) begin : g_r0
      assign set_vec[gi] = 1'b0;
    end else begin : g_rn
      assign set_vec[gi] = set_en && (set_addr == 4'(gi));
    end
  end

  // set is applied after clear so a new producer keeps ownership of its rd
  assign busy_next = flush ? '0 : ((busy_reg & ~clr_vec) | set_vec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign busy_eff = busy_reg & ~clr_vec;
`else
  assign busy_eff = busy_reg;
`endif

  assign hazard = ((rs1 != 4'd0) && busy_eff[rs1]) ||
                  (use_rs2 && (rs2 != 4'd0) && busy_eff[rs2]);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry holding register, combinational decode and scoreboard-based stall.
// Optional DECODE_WB_BYPASS_EN (see decode_scoreboard) lets issue happen in the writeback cycle.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int PC_W  = 16,
  parameter int NREGS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [15:0]    in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic           flush,
  output logic [3:0]     rf_raddr1,
  output logic [3:0]     rf_raddr2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [3:0]     out_rd,
  output logic [15:0]    out_imm,
  output alu_mux_sel_t   out_alu_sel,
  output logic [1:0]     out_alu_func,
  output x_op1_mux_sel_t out_op1_sel,
  output x_op2_mux_sel_t out_op2_sel,
  output w_mux_sel_t     out_w_sel,
  output logic           out_reg_we,
  output logic           out_illegal,
  input  logic           wb_valid,
  input  logic [3:0]     wb_addr
);

  logic            held_valid_reg, held_valid_next;
  logic [15:0]     held_instr_reg, held_instr_next;
  logic [PC_W-1:0] held_pc_reg, held_pc_next;
  decoded_instr_t  dec;
  logic            hazard;
  logic            issue;
  logic            accept;

  assign dec = decode_instr(held_instr_reg);

  decode_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (issue && dec.reg_we),
    .set_addr (dec.rd),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .rs1      (held_instr_reg[7:4]),
    .rs2      (held_instr_reg[3:0]),
    .use_rs2  (dec.op2_sel == REG2_DATA),
    .hazard   (hazard)
  );

  // flush wins over both an issue and an accept in the same cycle
  assign out_valid = held_valid_reg && !hazard && !flush;
  assign issue     = out_valid && out_ready;
  assign in_ready  = !flush && (!held_valid_reg || issue);
  assign accept    = in_valid && in_ready;

  always_comb begin
    held_valid_next = held_valid_reg;
    held_instr_next = held_instr_reg;
    held_pc_next    = held_pc_reg;
    if (flush) begin
      held_valid_next = 1'b0;
      held_instr_next = '0;
      held_pc_next    = '0;
    end else if (accept) begin
      held_valid_next = 1'b1;
      held_instr_next = in_instr;
      held_pc_next    = in_pc;
    end else if (issue) begin
      held_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid_reg <= 1'b0;
      held_instr_reg <= '0;
      held_pc_reg    <= '0;
    end else begin
      held_valid_reg <= held_valid_next;
      held_instr_reg <= held_instr_next;
      held_pc_reg    <= held_pc_next;
    end
  end

  assign rf_raddr1    = held_instr_reg[7:4];
  assign rf_raddr2    = held_instr_reg[3:0];
  assign out_pc       = held_pc_reg;
  assign out_rd       = dec.rd;
  assign out_imm      = dec.imm;
  assign out_alu_sel  = dec.alu_sel;
  assign out_alu_func = dec.alu_func;
  assign out_op1_sel  = dec.op1_sel;
  assign out_op2_sel  = dec.op2_sel;
  assign out_w_sel    = dec.w_sel;
  assign out_reg_we   = dec.reg_we;
  assign out_illegal  = dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, hazard/flush/reset sequences
// and a randomized run against a behavioural model of the stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int PC_W = 16;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0]     in_instr, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [3:0]      rf_raddr1, rf_raddr2, out_rd, wb_addr;
  alu_mux_sel_t    out_alu_sel;
  logic [1:0]      out_alu_func;
  x_op1_mux_sel_t  out_op1_sel;
  x_op2_mux_sel_t  out_op2_sel;
  w_mux_sel_t      out_w_sel;
  logic            out_reg_we, out_illegal, wb_valid;

  decode_stage #(.PC_W(PC_W), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_sel(out_alu_sel), .out_alu_func(out_alu_func),
    .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel), .out_w_sel(out_w_sel),
    .out_reg_we(out_reg_we), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0;
  endtask

  task automatic do_flush();
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // ADD r1,r2,r3 issues, then SUB r5,r1,r2 sits stalled on r1
  task automatic setup_raw_stall();
    do_flush();
    in_valid = 1'b1; in_instr = 16'h1123; in_pc = 16'h0200;
    step();
    in_instr = 16'h2512; in_pc = 16'h0202;
    step();
    in_valid = 1'b0;
  endtask

  // Expected decode fields {rd, imm, alu_sel, alu_func, op2_sel, reg_we, illegal}
  function automatic logic [26:0] exp_fields(input logic [15:0] ins);
    int             op = int'(ins[15:12]);
    alu_mux_sel_t   alu = ARITH;
    logic [1:0]     fn = 2'd0;
    x_op2_mux_sel_t op2 = REG2_DATA;
    logic           we;
    logic           ill;
    if (op >= 1 && op <= 2) fn = 2'(op - 1);
    else if (op >= 3 && op <= 5) begin alu = LOGIC; fn = 2'(op - 3); end
    else if (op == 6 || op == 7) begin alu = SHIFT; fn = 2'(op - 6); end
    else if (op == 8) op2 = IMM_SIGNED;
    ill = (op > 8);
    we  = (op >= 1) && (op <= 8) && (ins[11:8] != 4'd0);
    return {ins[11:8], {{12{ins[3]}}, ins[3:0]}, alu, fn, op2, we, ill};
  endfunction

  function automatic logic [26:0] dut_fields();
    return {out_rd, out_imm, out_alu_sel, out_alu_func, out_op2_sel, out_reg_we, out_illegal};
  endfunction

  typedef struct {
    logic [15:0]    instr;
    logic [3:0]     rd;
    logic [15:0]    imm;
    alu_mux_sel_t   alu;
    logic [1:0]     func;
    x_op2_mux_sel_t op2;
    logic           we;
    logic           ill;
  } vec_t;

  vec_t vecs[12];

  // behavioural model state
  bit   [15:0] m_busy;
  bit          m_hv;
  logic [15:0] m_instr;
  logic [15:0] m_pc;

  initial begin
    vecs[0]  = '{16'h1123, 4'd1,  16'h0003, ARITH, 2'd0, REG2_DATA,  1'b1, 1'b0};
    vecs[1]  = '{16'h844F, 4'd4,  16'hFFFF, ARITH, 2'd0, IMM_SIGNED, 1'b1, 1'b0};
    vecs[2]  = '{16'h2512, 4'd5,  16'h0002, ARITH, 2'd1, REG2_DATA,  1'b1, 1'b0};
    vecs[3]  = '{16'h3678, 4'd6,  16'hFFF8, LOGIC, 2'd0, REG2_DATA,  1'b1, 1'b0};
    vecs[4]  = '{16'h4700, 4'd7,  16'h0000, LOGIC, 2'd1, REG2_DATA,  1'b1, 1'b0};
    vecs[5]  = '{16'h5A1F, 4'd10, 16'hFFFF, LOGIC, 2'd2, REG2_DATA,  1'b1, 1'b0};
    vecs[6]  = '{16'h6B27, 4'd11, 16'h0007, SHIFT, 2'd0, REG2_DATA,  1'b1, 1'b0};
    vecs[7]  = '{16'h7C3E, 4'd12, 16'hFFFE, SHIFT, 2'd1, REG2_DATA,  1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 4'd0,  16'h0000, ARITH, 2'd0, REG2_DATA,  1'b0, 1'b0};
    vecs[9]  = '{16'hF123, 4'd1,  16'h0003, ARITH, 2'd0, REG2_DATA,  1'b0, 1'b1};
    vecs[10] = '{16'h1023, 4'd0,  16'h0003, ARITH, 2'd0, REG2_DATA,  1'b0, 1'b0};
    vecs[11] = '{16'h8807, 4'd8,  16'h0007, ARITH, 2'd0, IMM_SIGNED, 1'b1, 1'b0};

    idle_in();
    #23;
    // reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_alu_sel", out_alu_sel, ARITH);
    chk("rst_alu_func", out_alu_func, 0);
    chk("rst_op1_sel", out_op1_sel, REG1_DATA);
    chk("rst_op2_sel", out_op2_sel, REG2_DATA);
    chk("rst_w_sel", out_w_sel, REG_WRITE);
    chk("rst_reg_we", out_reg_we, 0);
    chk("rst_illegal", out_illegal, 0);
    rst_n = 1'b1;
    step();

    // decode table: accept, check one cycle later, issue, flush
    for (int i = 0; i < 12; i++) begin
      do_flush();
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 16'h0100 + 16'(i);
      #2 chk("vec_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      #2;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_fields", dut_fields(),
          {vecs[i].rd, vecs[i].imm, vecs[i].alu, vecs[i].func, vecs[i].op2, vecs[i].we, vecs[i].ill});
      chk("vec_out_pc", out_pc, 16'h0100 + 16'(i));
      chk("vec_raddr", {rf_raddr1, rf_raddr2}, {vecs[i].instr[7:4], vecs[i].instr[3:0]});
      $display("vector %0d instr %h rd %0d imm %h", i, vecs[i].instr, out_rd, out_imm);
      step();
    end

    // RAW stall released by writeback
    setup_raw_stall();
    #2;
    chk("raw_stall_valid", out_valid, 0);
    chk("raw_stall_ready", in_ready, 0);
    step();
    #2 chk("raw_stall_valid2", out_valid, 0);
    wb_valid = 1'b1; wb_addr = 4'd1;
    #2 chk("raw_wb_cycle_valid", out_valid, BYP);
    step();
    wb_valid = 1'b0;
    #2;
    chk("raw_after_wb_valid", out_valid, !BYP);
    chk("raw_after_wb_rd", out_rd, 5);
    $display("raw sequence: SUB after ADD r1 released by writeback (bypass=%0d)", BYP);
    step();

    // out_ready low for 3 cycles holds everything
    do_flush();
    in_valid = 1'b1; in_instr = 16'h844F; in_pc = 16'h0300;
    step();
    in_instr = 16'h1234; in_pc = 16'h0302; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_imm", out_imm, 16'hFFFF);
      chk("hold_pc", out_pc, 16'h0300);
      chk("hold_op2", out_op2_sel, IMM_SIGNED);
      step();
    end
    out_ready = 1'b1;
    #2 chk("hold_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #2;
    chk("hold_next_pc", out_pc, 16'h0302);
    chk("hold_next_rd", out_rd, 2);
    chk("hold_next_stall_r4", out_valid, 0);
    $display("hold sequence: ADDI held 3 cycles, follower stalls on r4");
    step();

    // flush while stalled, with a competing accept
    setup_raw_stall();
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h1777; in_pc = 16'h0400;
    #2 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #2 chk("flush_out_valid", out_valid, 0);
    in_valid = 1'b1; in_instr = 16'h2512; in_pc = 16'h0404;
    #2 chk("flush_accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    #2 chk("flush_r1_no_stall", out_valid, 1);
    $display("flush sequence: held instr killed, r1 readable without stall");
    step();

    // illegal opcode and r0 destination never mark busy
    do_flush();
    in_valid = 1'b1; in_instr = 16'hF123; in_pc = 16'h0500;
    step();
    in_instr = 16'h2512;
    #2;
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", out_illegal, 1);
    chk("ill_we", out_reg_we, 0);
    step();
    in_instr = 16'h1023;
    #2 chk("ill_no_busy_r1", out_valid, 1);
    step();
    in_instr = 16'h2200;
    #2;
    chk("r0_valid", out_valid, 1);
    chk("r0_we", out_reg_we, 0);
    step();
    in_valid = 1'b0;
    #2 chk("r0_never_busy", out_valid, 1);
    $display("illegal/r0 sequence: no scoreboard bits set");
    step();

    // asynchronous reset during a stall
    setup_raw_stall();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_rd", out_rd, 0);
    step();
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_instr = 16'h2512; in_pc = 16'h0600;
    step();
    in_valid = 1'b0;
    #2 chk("arst_sb_cleared", out_valid, 1);
    $display("async reset sequence: state cleared mid-stall");
    step();

    // randomized run against the behavioural model
    do_flush();
    m_busy = '0; m_hv = 1'b0; m_instr = '0; m_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      bit [15:0]   be;
      bit          haz, ov, iss, ir, acc;
      logic [3:0]  op;
      logic [26:0] ef;
      in_valid  = ($urandom_range(3) != 0);
      op        = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 9)) : 4'($urandom_range(8, 0));
      in_instr  = {op, 4'($urandom_range(7)), 4'($urandom_range(7)), 4'($urandom)};
      in_pc     = 16'($urandom);
      out_ready = ($urandom_range(3) != 0);
      wb_valid  = ($urandom_range(2) == 0);
      wb_addr   = 4'($urandom_range(7));
      flush     = ($urandom_range(49) == 0);
      #2;
      be = m_busy;
      if (BYP && wb_valid) be[wb_addr] = 1'b0;
      haz = ((m_instr[7:4] != 0) && be[m_instr[7:4]]) ||
            ((m_instr[15:12] != 4'd8) && (m_instr[3:0] != 0) && be[m_instr[3:0]]);
      ov  = m_hv && !haz;
      iss = ov && out_ready && !flush;
      ir  = !flush && (!m_hv || iss);
      acc = in_valid && ir;
      ef  = exp_fields(m_instr);
      chk("rnd_in_ready", in_ready, ir);
      if (!flush) chk("rnd_out_valid", out_valid, ov);
      chk("rnd_fields", dut_fields(), ef);
      chk("rnd_out_pc", out_pc, m_pc);
      chk("rnd_raddr", {rf_raddr1, rf_raddr2}, m_instr[7:0]);
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (iss && ef[1]) m_busy[m_instr[11:8]] = 1'b1;
      if (flush) begin
        m_busy = '0; m_hv = 1'b0; m_instr = '0; m_pc = '0;
      end else if (acc) begin
        m_hv = 1'b1; m_instr = in_instr; m_pc = in_pc;
      end else if (iss) begin
        m_hv = 1'b0;
      end
      step();
    end
    $display("random run: 3000 cycles compared against model");

    idle_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Decode stage of the pipeline, sitting between instruction fetch and execute.
- Latches one 16-bit instruction per accepted transfer.
- Produces register-file read addresses, operand/ALU/writeback mux selects and a sign-extended immediate for the execute stage.
- A per-register scoreboard stalls issue on read-after-write hazards until writeback retires the producer.

Parameters:
PC_W, 16, width of the program counter carried alongside each instruction
NREGS, 16, number of architectural registers; r0 reads as zero and is never marked busy

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode can accept this cycle
in_instr  in  16  instruction word: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm4
in_pc  in  PC_W  pc of in_instr
flush  in  1  kill the held instruction and clear the scoreboard
rf_raddr1  out  4  register-file read address 1 (rs1 of the held instruction)
rf_raddr2  out  4  register-file read address 2 (rs2 of the held instruction)
out_valid  out  1  decoded instruction available to execute
out_ready  in  1  execute accepts this cycle
out_pc  out  PC_W  pc of the issued instruction
out_rd  out  4  destination register
out_imm  out  16  imm4 sign-extended to 16 bits
out_alu_sel  out  alu_mux_sel_t  ARITH / LOGIC / SHIFT
out_alu_func  out  2  function within the selected ALU group
out_op1_sel  out  x_op1_mux_sel_t  always REG1_DATA
out_op2_sel  out  x_op2_mux_sel_t  REG2_DATA or IMM_SIGNED
out_w_sel  out  w_mux_sel_t  always REG_WRITE
out_reg_we  out  1  instruction writes rd (deasserted when rd == 0)
out_illegal  out  1  undefined opcode; travels as a NOP with out_reg_we = 0
wb_valid  in  1  writeback retires a register write
wb_addr  in  4  register being retired

Behaviour:
- Reset values:
  - holding register empty; out_valid = 0; scoreboard all-clear.
  - out_pc, out_rd, out_imm = 0; out_alu_sel = ARITH; out_alu_func = 0.
  - out_op1_sel = REG1_DATA; out_op2_sel = REG2_DATA; out_w_sel = REG_WRITE; out_reg_we = 0; out_illegal = 0.
- Opcode map:
  - 0 NOP.
  - 1 ADD, 2 SUB: ARITH.
  - 3 AND, 4 OR, 5 XOR: LOGIC.
  - 6 SHL, 7 SHR: SHIFT.
  - 8 ADDI: ARITH, IMM_SIGNED.
  - 9 to 15: illegal.
- Pipeline: one holding register (skid depth 1).
- in_ready = !held_valid OR issue, where issue = held_valid AND !hazard AND out_ready.
- Decode outputs are combinational from the held instruction, so acceptance to out_valid is 1 cycle.
- Hazard: rs1 busy, or rs2 busy when op2 is REG2_DATA. Busy never applies to r0.
- out_valid = held_valid AND !hazard. While stalled, no output field changes.
- Scoreboard:
  - On issue with out_reg_we, set bit rd.
  - On wb_valid, clear bit wb_addr.
  - If both target the same register in the same cycle, set wins: the new producer owns it.
- flush (synchronous):
  - clear the holding register and every scoreboard bit.
  - in_ready = 0 that cycle; flush overrides an in-flight issue and accept.
- Back-to-back issue with no stall sustains 1 instruction/cycle.
- Reset asserted mid-stall returns to the reset values immediately (asynchronous).

Optional Feature:
DECODE_WB_BYPASS_EN:
- Defined: a source whose busy bit is being cleared by wb_valid/wb_addr this cycle is treated as not busy, so issue happens in the writeback cycle. The register file must forward its write data.
- Undefined: hazard uses only the registered busy bits, so issue happens one cycle after writeback.

Decomposition:
- Add to the shared package:
  - opcode_t enum (values 0 to 8).
  - alu_func constants.
  - decoded_instr_t struct packing all out_* fields.
- The existing mux-select enums are reused unchanged.
- One sub-module: decode_scoreboard. It holds the busy bitvector, the set/clear/flush logic and the hazard query, with the bypass macro localised there.

Test Plan:
- ADD r1,r2,r3 (0x1123) with out_ready = 1 → out_valid the next cycle; alu_sel = ARITH, op2 = REG2_DATA, rd = 1, reg_we = 1.
- ADDI r4,r4,-1 (0x844F) → out_imm = 0xFFFF, op2_sel = IMM_SIGNED.
- ADD r1 issued, then SUB r5,r1,r2 → SUB stalls with in_ready = 0. wb_valid with addr 1 at cycle N gives SUB issue at N+1 (macro off) or at N (macro on).
- out_ready low for 3 cycles with a valid instruction → outputs stable, in_ready = 0, no scoreboard change.
- flush while stalled on r1 → out_valid = 0 next cycle; a following read of r1 issues without stall.
- Opcode 0xF → out_illegal = 1, out_reg_we = 0, scoreboard unchanged; ADD r0,... → reg_we = 0, r0 never busy.
